parking_occupancy: RTL

- Upstream stage of the full-lot indicator. Turns raw entry/exit car sensors into a debounced occupancy count.
- Drives the level `full_signal` consumed by the full-LED blinker, plus grant/reject pulses for the entry gate.
- Single clock domain `clk_1Hz`; slow mechanical sensors sampled directly.

---
 rtl/parking_occupancy.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/parking_occupancy.sv
// parking_occupancy: debounced parking-lot occupancy counter.
//
// Each raw sensor goes through a 2-flop synchronizer and a four-state debounce FSM.
// The FSM produces exactly one event per car passage. Entry and exit events are
// resolved into a saturating occupancy count plus one-cycle gate pulses.
//
// Ports:
//   clk_1Hz       system clock, all logic on the rising edge
//   reset         asynchronous active-low reset, clears all state
//   entry_sensor  raw entry loop detector (high while a car is present)
//   exit_sensor   raw exit loop detector (high while a car is present)
//   count         cars currently parked
//   free_slots    CAPACITY - count
//   full_signal   lot-full level for the blinker
//   empty         count == 0
//   entry_grant   one-cycle pulse, entry accepted
//   entry_reject  one-cycle pulse, entry refused because the lot is full
//   exit_error    one-cycle pulse, exit seen while the lot is empty
//
// Build option:
//   FULL_HYST_EN  when defined, full_signal sets at count == CAPACITY and clears only
//                 once count <= CAPACITY-2 (count == 0 when CAPACITY == 1).
module parking_occupancy #(
  parameter int unsigned CAPACITY = 8,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic             clk_1Hz,
  input  logic             reset,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] free_slots,
  output logic             full_signal,
  output logic             empty,
  output logic             entry_grant,
  output logic             entry_reject,
  output logic             exit_error
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StArming    = 2'd1;
  localparam logic [1:0] StQualified = 2'd2;
  localparam logic [1:0] StReleasing = 2'd3;

  localparam logic [2:0]       DebMax = 3'(DEBOUNCE);
  localparam logic [CNT_W-1:0] Cap    = CNT_W'(CAPACITY);

  // Channel index 0 is entry, 1 is exit.
  logic [1:0] sync1_q, sync_q;
  logic [1:0] state_q [2];
  logic [1:0] state_d [2];
  logic [2:0] deb_q   [2];
  logic [2:0] deb_d   [2];
  logic [1:0] event_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free_q, free_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             grant_q, grant_d;
  logic             reject_q, reject_d;
  logic             error_q, error_d;

  // Debounce FSMs. The event is combinational so the count register updates on the
  // same edge the FSM enters QUALIFIED.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      deb_d[ch]   = deb_q[ch];
      event_d[ch] = 1'b0;
      case (state_q[ch])
        StIdle: begin
          if (sync_q[ch]) begin
            if (DebMax <= 3'd1) begin
              state_d[ch] = StQualified;
              deb_d[ch]   = 3'd0;
              event_d[ch] = 1'b1;
            end else begin
              state_d[ch] = StArming;
              deb_d[ch]   = 3'd1;
            end
          end
        end
        StArming: begin
          if (sync_q[ch]) begin
            if (deb_q[ch] + 3'd1 >= DebMax) begin
              state_d[ch] = StQualified;
              deb_d[ch]   = 3'd0;
              event_d[ch] = 1'b1;
            end else begin
              deb_d[ch] = deb_q[ch] + 3'd1;
            end
          end else begin
            // Glitch shorter than the debounce window.
            state_d[ch] = StIdle;
            deb_d[ch]   = 3'd0;
          end
        end
        StQualified: begin
          if (!sync_q[ch]) begin
            if (DebMax <= 3'd1) begin
              state_d[ch] = StIdle;
              deb_d[ch]   = 3'd0;
            end else begin
              state_d[ch] = StReleasing;
              deb_d[ch]   = 3'd1;
            end
          end
        end
        StReleasing: begin
          if (!sync_q[ch]) begin
            if (deb_q[ch] + 3'd1 >= DebMax) begin
              state_d[ch] = StIdle;
              deb_d[ch]   = 3'd0;
            end else begin
              deb_d[ch] = deb_q[ch] + 3'd1;
            end
          end else begin
            // Car still present; return without a new event.
            state_d[ch] = StQualified;
            deb_d[ch]   = 3'd0;
          end
        end
        default: begin
          state_d[ch] = StIdle;
          deb_d[ch]   = 3'd0;
        end
      endcase
    end
  end

  // Event resolution. With simultaneous events the exit is applied first, so the
  // entry is always granted.
  always_comb begin
    count_d  = count_q;
    grant_d  = 1'b0;
    reject_d = 1'b0;
    error_d  = 1'b0;
    case (event_d)
      2'b10: begin
        if (count_q == '0) begin
          error_d = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      2'b01: begin
        if (count_q == Cap) begin
          reject_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
          grant_d = 1'b1;
        end
      end
      2'b11: begin
        grant_d = 1'b1;
        if (count_q == '0) begin
          error_d = 1'b1;
          count_d = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Status flags derive from count_d so they are aligned with the registered count.
  always_comb begin
    free_d  = Cap - count_d;
    empty_d = (count_d == '0);
`ifdef FULL_HYST_EN
    if (count_d == Cap) begin
      full_d = 1'b1;
    end else if ((CAPACITY >= 2) && (32'(count_d) + 32'd2 <= 32'(CAPACITY))) begin
      full_d = 1'b0;
    end else if ((CAPACITY < 2) && (count_d == '0)) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
`else
    full_d = (count_d == Cap);
`endif
  end

  always_ff @(posedge clk_1Hz or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 2'b00;
      sync_q     <= 2'b00;
      state_q[0] <= StIdle;
      state_q[1] <= StIdle;
      deb_q[0]   <= 3'd0;
      deb_q[1]   <= 3'd0;
      count_q    <= '0;
      free_q     <= Cap;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      grant_q    <= 1'b0;
      reject_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      sync1_q    <= {exit_sensor, entry_sensor};
      sync_q     <= sync1_q;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      deb_q[0]   <= deb_d[0];
      deb_q[1]   <= deb_d[1];
      count_q    <= count_d;
      free_q     <= free_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      grant_q    <= grant_d;
      reject_q   <= reject_d;
      error_q    <= error_d;
    end
  end

  assign count        = count_q;
  assign free_slots   = free_q;
  assign full_signal  = full_q;
  assign empty        = empty_q;
  assign entry_grant  = grant_q;
  assign entry_reject = reject_q;
  assign exit_error   = error_q;

endmodule
